dbus_mmio_bridge: RTL
=====================

// Module: dbus_mmio_bridge
// PURPOSE
//  Sits between the core data port and the RAM data port; steers accesses in an MMIO window to local regs, all else to RAM.
//  Local regs: console TX byte FIFO (drained by testbench/UART model), sticky program-exit register, 64-bit cycle counter.
//  Replaces exit detection inside RAM; exit_valid_o/exit_value_o feed top-level program_exit logic.
// PARAMETERS
//  MMIO_BASE   32'h1000_0000  base of 4 KiB MMIO window (addr[31:12] match)
//  FIFO_DEPTH  8              console TX FIFO entries, power of 2, >=2
// PORTS
//  clk_i          in   1   clock, all logic on rising edge
//  rst_i          in   1   synchronous, active-high reset
//  data_req_i     in   1   core request
//  data_addr_i    in   32  core byte address
//  data_we_i      in   1   1=write
//  data_be_i      in   4   byte enables
//  data_wdata_i   in   32  write data
//  data_gnt_o     out  1   grant to core
//  data_rvalid_o  out  1   response valid to core
//  data_rdata_o   out  32  read data to core
//  mem_req_o/mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o  out 1/32/1/4/32  pass-through to RAM
//  mem_gnt_i      in   1   RAM grant
//  mem_rvalid_i   in   1   RAM response valid
//  mem_rdata_i    in   32  RAM read data
//  tx_valid_o     out  1   console byte available
//  tx_data_o      out  8   console byte (FIFO head)
//  tx_ready_i     in   1   consumer accepts byte when valid&ready
//  exit_valid_o   out  1   sticky: program wrote EXIT
//  exit_value_o   out  32  value written to EXIT
// BEHAVIOUR
//  Decode: sel_mmio = data_addr_i[31:12]==MMIO_BASE[31:12]; offset = data_addr_i[11:0].
//  Single outstanding txn: flag pend (+ pend_src: RAM/MMIO). Grant only when pend==0 or response retires this cycle.
//  RAM path: mem_req_o = data_req_i & ~sel_mmio & can_issue; data_gnt_o = mem_gnt_i in that case; pend set on gnt.
//  MMIO path: granted same cycle data_req_i seen (if can_issue & not stalled); data_rvalid_o exactly 1 cycle after gnt.
//  Response mux: pend_src==RAM -> mem_rvalid_i/mem_rdata_i; MMIO -> registered rdata. Never both same cycle.
//  Regs (offset): 0x00 TX_DATA W: push wdata[7:0] (be[0] req'd, else ignored); R: 0.
//   0x04 TX_STAT R: {23'b0, full, level[7:0]} with level zero-extended; W ignored.
//   0x08 EXIT W: first write sets exit_valid_o=1, exit_value_o=wdata; later writes ignored; R: exit_value_o.
//   0x0C CYC_LO R: cycle[31:0]; snapshots cycle[63:32] into hi_shadow same cycle.
//   0x10 CYC_HI R: hi_shadow. Writes to CYC_* ignored. Other offsets: R 0, W ignored, still granted.
//  Cycle counter: 64-bit, +1 every clock from reset, wraps 2^64-1 -> 0.
//  TX write when FIFO full: data_gnt_o held 0 (stall) until a pop frees space; pop and push same cycle legal when full
//   only if pop occurs (grant same cycle). Simultaneous push+pop when not full/empty: level unchanged.
//  tx_valid_o = ~empty; tx_data_o = head, stable while valid & ~ready.
//  Reset: data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, mem_req_o=0, pend=0, FIFO empty (tx_valid_o=0, tx_data_o=0),
//   exit_valid_o=0, exit_value_o=0, cycle=0, hi_shadow=0. Reset mid-transaction drops pend; a late mem_rvalid_i
//   with pend==0 is ignored (not forwarded).
// STRUCTURE
//  Package dbus_mmio_pkg: offset localparams (TX_DATA, TX_STAT, EXIT, CYC_LO, CYC_HI), pend_src enum.
//  Sub-module mmio_tx_fifo (sync FIFO, DEPTH param, push/pop/full/empty/level); rest inline in bridge.
// TESTING
//  RAM pass: LW 0x0000_0100 -> mem_req_o=1, addr passthru, core rvalid follows mem_rvalid_i with mem_rdata_i.
//  Console: SW 0x41,0x42 to MMIO_BASE+0 with tx_ready_i=0 -> TX_STAT reads 2; raise ready -> bytes 0x41 then 0x42.
//  Full stall: 9th SW with FIFO_DEPTH=8, ready=0 -> gnt 0; ready pulse 1 cycle -> gnt same cycle, level stays 8.
//  Exit: SW 0x0 then 0x5 to +0x08 -> exit_valid_o=1 next cycle, exit_value_o=0, stays 0 after second write.
//  Cycle: reset, 100 clocks, LW +0x0C -> value in [100,102]; force cycle=32'hFFFF_FFFF low -> CYC_HI read == snapshot.
//  Reset while RAM read pending -> no data_rvalid_o after reset even if mem_rvalid_i arrives; all outputs at reset values.

Source files
------------

// File: rtl/dbus_mmio_pkg.sv
// Shared register offsets and transaction-source encoding for the data-bus MMIO bridge.
package dbus_mmio_pkg;
  localparam logic [11:0] TX_DATA = 12'h000;
  localparam logic [11:0] TX_STAT = 12'h004;
  localparam logic [11:0] EXIT    = 12'h008;
  localparam logic [11:0] CYC_LO  = 12'h00C;
  localparam logic [11:0] CYC_HI  = 12'h010;

  typedef enum logic {
    SRC_RAM  = 1'b0,
    SRC_MMIO = 1'b1
  } pend_src_e;
endpackage

// File: rtl/dbus_mmio_bridge_fifo.sv
// Console TX byte FIFO: synchronous, power-of-two depth, push accepted when full only alongside a pop.
module mmio_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == (AW+1)'(0));
  assign level_o = level_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/dbus_mmio_bridge.sv
// Core data-port splitter: a 4 KiB MMIO window goes to local console/exit/cycle registers,
// everything else passes through to RAM. One transaction outstanding at a time.
module dbus_mmio_bridge
  import dbus_mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic            pend_q;
  pend_src_e       src_q;
  logic            mmio_rvalid_q;
  logic [31:0]     mmio_rdata_q;
  logic [31:0]     mmio_rdata_d;
  logic            exit_valid_q;
  logic [31:0]     exit_value_q;
  logic [63:0]     cycle_q;
  logic [31:0]     hi_shadow_q;

  logic            sel_mmio;
  logic [11:0]     offset;
  logic            retire;
  logic            can_issue;
  logic            tx_push_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LW-1:0]   fifo_level;
  logic            fifo_pop;
  logic            mmio_gnt;
  logic            ram_req;
  logic            ram_rvalid;

  assign sel_mmio = (data_addr_i[31:12] == MMIO_BASE[31:12]);
  assign offset   = data_addr_i[11:0];

  // An MMIO response always retires the cycle after its grant; RAM retires on mem_rvalid_i.
  assign retire    = pend_q & ((src_q == SRC_MMIO) | mem_rvalid_i);
  assign can_issue = ~pend_q | retire;

  assign tx_push_req = data_req_i & sel_mmio & data_we_i & (offset == TX_DATA) & data_be_i[0];
  assign fifo_pop    = ~fifo_empty & tx_ready_i;
  assign mmio_gnt    = ~rst_i & data_req_i & sel_mmio & can_issue
                     & ~(tx_push_req & fifo_full & ~fifo_pop);
  assign ram_req     = ~rst_i & data_req_i & ~sel_mmio & can_issue;

  assign mem_req_o   = ram_req;
  assign mem_addr_o  = data_addr_i;
  assign mem_we_o    = data_we_i;
  assign mem_be_o    = data_be_i;
  assign mem_wdata_o = data_wdata_i;
  assign data_gnt_o  = mmio_gnt | (ram_req & mem_gnt_i);

  // A stray mem_rvalid_i with nothing pending (e.g. after reset) is dropped here.
  assign ram_rvalid    = ~rst_i & pend_q & (src_q == SRC_RAM) & mem_rvalid_i;
  assign data_rvalid_o = ram_rvalid | (~rst_i & mmio_rvalid_q);
  assign data_rdata_o  = ram_rvalid ? mem_rdata_i
                       : ((~rst_i & mmio_rvalid_q) ? mmio_rdata_q : 32'h0000_0000);

  assign tx_valid_o   = ~fifo_empty;
  assign exit_valid_o = exit_valid_q;
  assign exit_value_o = exit_value_q;

  // MMIO read-data mux, evaluated on the grant cycle.
  always_comb begin
    mmio_rdata_d = 32'h0000_0000;
    if (!data_we_i) begin
      case (offset)
        TX_STAT: mmio_rdata_d = {23'b0, fifo_full, 8'(fifo_level)};
        EXIT:    mmio_rdata_d = exit_value_q;
        CYC_LO:  mmio_rdata_d = cycle_q[31:0];
        CYC_HI:  mmio_rdata_d = hi_shadow_q;
        default: mmio_rdata_d = 32'h0000_0000;
      endcase
    end else begin
      mmio_rdata_d = 32'h0000_0000;
    end
  end

  mmio_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (mmio_gnt & tx_push_req),
    .data_i  (data_wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (tx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q        <= 1'b0;
      src_q         <= SRC_RAM;
      mmio_rvalid_q <= 1'b0;
      mmio_rdata_q  <= 32'h0000_0000;
      exit_valid_q  <= 1'b0;
      exit_value_q  <= 32'h0000_0000;
      cycle_q       <= 64'h0;
      hi_shadow_q   <= 32'h0000_0000;
    end else begin
      cycle_q       <= cycle_q + 64'd1;
      mmio_rvalid_q <= mmio_gnt;
      mmio_rdata_q  <= mmio_gnt ? mmio_rdata_d : 32'h0000_0000;
      if (data_gnt_o) begin
        pend_q <= 1'b1;
        src_q  <= mmio_gnt ? SRC_MMIO : SRC_RAM;
      end else if (retire) begin
        pend_q <= 1'b0;
      end
      if (mmio_gnt && data_we_i && (offset == EXIT) && !exit_valid_q) begin
        exit_valid_q <= 1'b1;
        exit_value_q <= data_wdata_i;
      end
      // Reading the low word freezes the high word so a LO/HI pair is coherent.
      if (mmio_gnt && !data_we_i && (offset == CYC_LO)) begin
        hi_shadow_q <= cycle_q[63:32];
      end
    end
  end
endmodule
